// File: rtl/rca_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rca_pipe
// Description : Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry
//               chain is split into WIDTH/SEG segments. Each segment has one
//               register stage, so a result appears WIDTH/SEG enabled edges
//               after its operands are sampled. One operation is accepted per
//               enabled cycle.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               en        - clock enable; 0 freezes every register
//               in_valid  - a/b/cin/sub hold a new operation
//               a, b      - WIDTH-bit operands
//               cin       - carry-in (add) / borrow-in (sub)
//               sub       - 0: a+b+cin, 1: a-b-cin
//               out_valid - sum/cout/ovf hold a completed result
//               sum       - result modulo 2^WIDTH
//               cout      - carry out of the MSB (sub: 1 = no borrow)
//               ovf       - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module rca_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // SEG is clamped only to keep the divisions below legal while the
    // parameter check reports the real problem.
    localparam int c_SEG_SAFE  = (SEG >= 1) ? SEG : 1;
    localparam bit c_PARAMS_OK = (SEG >= 1) && ((WIDTH % c_SEG_SAFE) == 0);
    localparam int c_NSEG      = WIDTH / c_SEG_SAFE;

    if (!c_PARAMS_OK) begin : g_param_check
        $fatal(1, "rca_pipe: WIDTH (%0d) must be a positive multiple of SEG (%0d)",
               WIDTH, SEG);
    end

    // Subtraction is a + ~b + 1; the borrow-in is folded into the inverted carry.
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    assign w_b_eff = sub ? ~b : b;
    assign w_c_eff = sub ? ~cin : cin;

    // ------------------------------------------------------------------------
    // Stage k adds segment k. Each stage owns:
    //   r_lo      : completed sum bits [0 +: (k+1)*SEG] (earlier segments are
    //               carried along so all sum bits leave together)
    //   g_fwd.r_ha/r_hb : operand bits not yet added (absent in the last stage)
    //   r_c, r_v  : carry out of this segment and the slot's valid bit
    // The last stage's registers are the outputs and only load on valid
    // slots, so bubbles leave the previous result on sum/cout/ovf.
    // ------------------------------------------------------------------------
    genvar k;
    for (k = 0; k < c_NSEG; k++) begin : g_stage
        logic [SEG-1:0]         w_sa;
        logic [SEG-1:0]         w_sb;
        logic                   w_ci;
        logic                   w_vi;
        logic [SEG-1:0]         w_s;
        logic [SEG:0]           w_cc;
        logic [(k+1)*SEG-1:0]   w_lo_nxt;

        logic [(k+1)*SEG-1:0]   r_lo;
        logic                   r_c;
        logic                   r_v;

        if (k == 0) begin : g_head
            assign w_sa     = a[SEG-1:0];
            assign w_sb     = w_b_eff[SEG-1:0];
            assign w_ci     = w_c_eff;
            assign w_vi     = in_valid;
            assign w_lo_nxt = w_s;
        end else begin : g_body
            assign w_sa     = g_stage[k-1].g_fwd.r_ha[SEG-1:0];
            assign w_sb     = g_stage[k-1].g_fwd.r_hb[SEG-1:0];
            assign w_ci     = g_stage[k-1].r_c;
            assign w_vi     = g_stage[k-1].r_v;
            assign w_lo_nxt = {w_s, g_stage[k-1].r_lo};
        end

        // Plain ripple chain: bit i waits for the carry of bit i-1.
        always_comb begin
            w_cc    = '0;
            w_s     = '0;
            w_cc[0] = w_ci;
            for (int i = 0; i < SEG; i++) begin
                w_s[i]    = w_sa[i] ^ w_sb[i] ^ w_cc[i];
                w_cc[i+1] = (w_sa[i] & w_sb[i]) | (w_cc[i] & (w_sa[i] ^ w_sb[i]));
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lo <= '0;
                r_c  <= 1'b0;
                r_v  <= 1'b0;
            end else if (en) begin
                r_v <= w_vi;
                if ((k != c_NSEG - 1) || w_vi) begin
                    r_lo <= w_lo_nxt;
                    r_c  <= w_cc[SEG];
                end
            end
        end

        // Operand skew: upper segments wait here until their carry arrives.
        if (k < c_NSEG - 1) begin : g_fwd
            logic [WIDTH-(k+1)*SEG-1:0] w_ha_in;
            logic [WIDTH-(k+1)*SEG-1:0] w_hb_in;
            logic [WIDTH-(k+1)*SEG-1:0] r_ha;
            logic [WIDTH-(k+1)*SEG-1:0] r_hb;

            if (k == 0) begin : g_src0
                assign w_ha_in = a[WIDTH-1:SEG];
                assign w_hb_in = w_b_eff[WIDTH-1:SEG];
            end else begin : g_srcn
                assign w_ha_in = g_stage[k-1].g_fwd.r_ha[WIDTH-k*SEG-1:SEG];
                assign w_hb_in = g_stage[k-1].g_fwd.r_hb[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ha <= '0;
                    r_hb <= '0;
                end else if (en) begin
                    r_ha <= w_ha_in;
                    r_hb <= w_hb_in;
                end
            end
        end

        if (k == c_NSEG - 1) begin : g_tail
            logic r_ovf;

            // Overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (en && w_vi) begin
                    r_ovf <= w_cc[SEG] ^ w_cc[SEG-1];
                end
            end

            assign sum       = r_lo;
            assign cout      = r_c;
            assign ovf       = r_ovf;
            assign out_valid = r_v;
        end
    end

endmodule
`default_nettype wire
